riscv_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal). It sequences a shared-memory datapath over 3-5 cycles per instruction. It drives the same ALU encoding, immediate-select and result-select semantics as the single-cycle control unit. A ready handshake lets instruction/data memory stall the FSM.

---
 rtl/riscv_multicycle_ctrl_if.sv | 9 +
 rtl/riscv_multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_multicycle_ctrl_if.sv
// riscv_multicycle_ctrl_if: shared memory bus between the control FSM and instruction/data memory
interface riscv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;
  modport master (output mem_req, output mem_write, output adr_src, input mem_ready);
  modport slave (input mem_req, input mem_write, input adr_src, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: RV32I multicycle control FSM; define RISCV_MC_PERF_EN to add cycle/instret counters
module riscv_multicycle_ctrl #(
  parameter int RESET_WAIT = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  riscv_multicycle_ctrl_if.master       mem,
  input  logic                          zero_i,
  input  logic [6:0]                    op_i,
  input  logic [2:0]                    funct3_i,
  input  logic                          funct7b5_i,
  output logic                          ir_write_o,
  output logic                          pc_write_o,
  output logic                          reg_write_o,
  output logic [1:0]                    result_src_o,
  output logic [1:0]                    alu_src_a_o,
  output logic [1:0]                    alu_src_b_o,
  output logic [1:0]                    imm_src_o,
  output logic [2:0]                    alu_control_o,
  output logic                          illegal_op_o
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [31:0]                   cycle_cnt_o,
  output logic [31:0]                   instret_cnt_o
`endif
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
  localparam int CW = RESET_WAIT > 1 ? $clog2(RESET_WAIT) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic idle_done;
  logic [2:0] alu_dec;
  assign idle_done = (RESET_WAIT <= 1) || (idle_cnt_q == CW'(RESET_WAIT - 1));
  // funct3 decode shared by register and immediate ALU ops; sub only for R-type with bit 30 set
  assign alu_dec = funct3_i == 3'b000 ? ((op_i[5] & funct7b5_i) ? 3'b001 : 3'b000) :
                   funct3_i == 3'b010 ? 3'b101 :
                   funct3_i == 3'b110 ? 3'b011 :
                   funct3_i == 3'b111 ? 3'b010 : 3'b000;
  // next-state sequencing; unknown encodings fall back to fetch
  always_comb begin
    state_d = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      S_IDLE: begin
        idle_cnt_d = idle_done ? idle_cnt_q : idle_cnt_q + CW'(1);
        state_d = idle_done ? S_FETCH : S_IDLE;
      end
      S_FETCH:    state_d = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = (op_i == 7'b0000011 || op_i == 7'b0100011) ? S_MEMADR :
                            op_i == 7'b0110011 ? S_EXECR :
                            op_i == 7'b0010011 ? S_EXECI :
                            op_i == 7'b1100011 ? S_BEQ :
                            op_i == 7'b1101111 ? S_JAL : S_FETCH;
      S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end
  // state and idle counter; reset forces idle so every enable drops at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
  // Moore outputs from state, with ready-gated fetch enables and zero-gated branch
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_write = 1'b0;
    mem.adr_src = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    reg_write_o = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o = 2'b00;
    alu_src_b_o = 2'b00;
    imm_src_o = 2'b00;
    alu_control_o = 3'b000;
    illegal_op_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        ir_write_o = mem.mem_ready;
        pc_write_o = mem.mem_ready;
        alu_src_b_o = 2'b10;
        result_src_o = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        imm_src_o = 2'b10;
        illegal_op_o = !(op_i == 7'b0000011 || op_i == 7'b0100011 || op_i == 7'b0110011 ||
                         op_i == 7'b0010011 || op_i == 7'b1100011 || op_i == 7'b1101111);
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        imm_src_o = op_i[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem.mem_req = 1'b1;
        mem.adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o = 1'b1;
      end
      S_MEMWRITE: begin
        mem.mem_req = 1'b1;
        mem.mem_write = 1'b1;
        mem.adr_src = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_control_o = alu_dec;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_control_o = alu_dec;
      end
      S_ALUWB: reg_write_o = 1'b1;
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_control_o = 3'b001;
        pc_write_o = zero_i;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o = 1'b1;
      end
      default: ;
    endcase
  end
`ifdef RISCV_MC_PERF_EN
  logic retire;
  assign retire = state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_BEQ ||
                  (state_q == S_MEMWRITE && mem.mem_ready);
  // free-running performance counters, wrapping naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_o <= '0;
      instret_cnt_o <= '0;
    end else begin
      cycle_cnt_o <= state_q != S_IDLE ? cycle_cnt_o + 32'd1 : cycle_cnt_o;
      instret_cnt_o <= retire ? instret_cnt_o + 32'd1 : instret_cnt_o;
    end
  end
`endif
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl: directed control-word checks for the multicycle FSM
module tb_riscv_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic zero = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic funct7b5 = 1'b0;
  logic ir_write, pc_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  int checks = 0;
  int errs = 0;
  riscv_multicycle_ctrl_if bus ();
`ifdef RISCV_MC_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  riscv_multicycle_ctrl #(.RESET_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus.master), .zero_i(zero), .op_i(op),
    .funct3_i(funct3), .funct7b5_i(funct7b5), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .reg_write_o(reg_write), .result_src_o(result_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .imm_src_o(imm_src), .alu_control_o(alu_control),
    .illegal_op_o(illegal_op)
`ifdef RISCV_MC_PERF_EN
    , .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt)
`endif
  );
  always #5 clk = ~clk;
  wire logic [17:0] ctl = {bus.mem_req, bus.mem_write, bus.adr_src, ir_write, pc_write, reg_write,
                           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_op};
  localparam logic [17:0] C_IDLE   = 18'b0;
  localparam logic [17:0] C_FETCH  = 18'b1_0_0_1_1_0_10_00_10_00_000_0;
  localparam logic [17:0] C_FSTALL = 18'b1_0_0_0_0_0_10_00_10_00_000_0;
  localparam logic [17:0] C_DEC    = 18'b0_0_0_0_0_0_00_01_01_10_000_0;
  localparam logic [17:0] C_ILL    = 18'b0_0_0_0_0_0_00_01_01_10_000_1;
  localparam logic [17:0] C_ADR_L  = 18'b0_0_0_0_0_0_00_10_01_00_000_0;
  localparam logic [17:0] C_ADR_S  = 18'b0_0_0_0_0_0_00_10_01_01_000_0;
  localparam logic [17:0] C_MRD    = 18'b1_0_1_0_0_0_00_00_00_00_000_0;
  localparam logic [17:0] C_MWB    = 18'b0_0_0_0_0_1_01_00_00_00_000_0;
  localparam logic [17:0] C_MWR    = 18'b1_1_1_0_0_0_00_00_00_00_000_0;
  localparam logic [17:0] C_WB     = 18'b0_0_0_0_0_1_00_00_00_00_000_0;
  localparam logic [17:0] C_JAL    = 18'b0_0_0_0_1_0_00_01_10_00_000_0;
  function automatic logic [17:0] c_execr(input logic [2:0] alu);
    return {14'b000000_00_10_00_00, alu, 1'b0};
  endfunction
  function automatic logic [17:0] c_execi(input logic [2:0] alu);
    return {14'b000000_00_10_01_00, alu, 1'b0};
  endfunction
  function automatic logic [17:0] c_beq(input logic z);
    return {4'b0000, z, 1'b0, 8'b00_10_00_00, 3'b001, 1'b0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [17:0] exp);
    #1 chk(tag, 32'(ctl), 32'(exp));
    @(negedge clk);
  endtask
  task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [17:0] exec);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    step({tag, "_fetch"}, C_FETCH);
    step({tag, "_dec"}, C_DEC);
    step({tag, "_exec"}, exec);
    step({tag, "_wb"}, C_WB);
  endtask
  initial begin
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    step("rst", C_IDLE);
    rst_n = 1'b1;
    step("idle0", C_IDLE);
    step("idle1", C_IDLE);
    step("lw_fetch", C_FETCH);
    step("lw_dec", C_DEC);
    step("lw_adr", C_ADR_L);
    step("lw_rd", C_MRD);
    step("lw_wb", C_MWB);
    op = 7'b0100011;
    step("sw_fetch", C_FETCH);
    step("sw_dec", C_DEC);
    step("sw_adr", C_ADR_S);
    bus.mem_ready = 1'b0;
    repeat (3) step("sw_stall", C_MWR);
    bus.mem_ready = 1'b1;
    step("sw_wr", C_MWR);
    bus.mem_ready = 1'b0;
    step("fetch_stall", C_FSTALL);
    bus.mem_ready = 1'b1;
    alu_instr("r_sub", 7'b0110011, 3'b000, 1'b1, c_execr(3'b001));
    alu_instr("i_add", 7'b0010011, 3'b000, 1'b1, c_execi(3'b000));
    alu_instr("r_slt", 7'b0110011, 3'b010, 1'b0, c_execr(3'b101));
    alu_instr("r_or", 7'b0110011, 3'b110, 1'b0, c_execr(3'b011));
    alu_instr("i_and", 7'b0010011, 3'b111, 1'b0, c_execi(3'b010));
    alu_instr("r_oth", 7'b0110011, 3'b001, 1'b1, c_execr(3'b000));
    op = 7'b1100011;
    zero = 1'b1;
    step("beq1_fetch", C_FETCH);
    step("beq1_dec", C_DEC);
    step("beq1_ex", c_beq(1'b1));
    zero = 1'b0;
    step("beq0_fetch", C_FETCH);
    step("beq0_dec", C_DEC);
    step("beq0_ex", c_beq(1'b0));
    op = 7'b1101111;
    step("jal_fetch", C_FETCH);
    step("jal_dec", C_DEC);
    step("jal_ex", C_JAL);
    step("jal_wb", C_WB);
    op = 7'b1110011;
    step("ill_fetch", C_FETCH);
    step("ill_dec", C_ILL);
    op = 7'b0000011;
    step("ill_next", C_FETCH);
    step("ab_dec", C_DEC);
    step("ab_adr", C_ADR_L);
    bus.mem_ready = 1'b0;
    step("ab_rd_stall", C_MRD);
    #1 chk("ab_rd", 32'(ctl), 32'(C_MRD));
    #2 rst_n = 1'b0;
    #1 chk("ab_async", 32'(ctl), 32'(C_IDLE));
    @(negedge clk);
    bus.mem_ready = 1'b1;
    rst_n = 1'b1;
    step("re_idle0", C_IDLE);
    step("re_idle1", C_IDLE);
    step("re_fetch", C_FETCH);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
